// File: rtl/start_bit_det_if.sv
// Serial line interface: the raw asynchronous input and the start-bit pulse.
// Latency: none (wires only).
// Backpressure: none; the line is free-running and the pulse is fire-and-forget.
//
// Signals:
//   serial_in          - asynchronous serial line, idle = 1
//   start_bit_detected - one-cycle pulse on a synchronized 1->0 transition
interface start_bit_det_if;
  logic serial_in;
  logic start_bit_detected;

  // master: line driver and pulse consumer (e.g. receiver controller)
  modport master (
    output serial_in,
    input  start_bit_detected
  );

  // slave: the detector itself
  modport slave (
    input  serial_in,
    output start_bit_detected
  );
endinterface

// File: rtl/start_bit_det.sv
// Start-bit detector: synchronizes an idle-high serial line and flags 1->0 edges.
// Latency: pulse rises SYNC_STAGES edges after the line falls, lasts exactly 1 cycle.
// Backpressure: none; every captured falling edge is reported, no gating or filtering.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   n_rst - asynchronous active-low reset, forces the whole chain to idle (1)
//   bus   - slave side of start_bit_det_if (serial_in in, start_bit_detected out)
module start_bit_det #(
  parameter int SYNC_STAGES = 2  // flops between serial_in and new_sample, >= 2
) (
  input  logic            clk,
  input  logic            n_rst,
  start_bit_det_if.slave  bus
);

  // Chain: sync[0] .. sync[SYNC_STAGES-2] -> new_sample -> old_sample.
  // Only sync_q[0] may go metastable; the output logic sees the last two flops.
  logic [SYNC_STAGES-2:0] sync_q;
  logic [SYNC_STAGES-2:0] sync_d;
  logic                   new_sample_q;
  logic                   new_sample_d;
  logic                   old_sample_q;
  logic                   old_sample_d;

  always_comb begin
    sync_d       = sync_q;
    sync_d[0]    = bus.serial_in;
    for (int i = 1; i < SYNC_STAGES - 1; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    new_sample_d = sync_q[SYNC_STAGES-2];
    old_sample_d = new_sample_q;
  end

  // Reset loads the idle level so a line held low through reset cannot
  // produce a pulse at release; it is reported once it has crossed the chain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q       <= '1;
      new_sample_q <= 1'b1;
      old_sample_q <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      new_sample_q <= new_sample_d;
      old_sample_q <= old_sample_d;
    end
  end

  // Purely from registered state, so no glitches propagate from serial_in.
  assign bus.start_bit_detected = old_sample_q & ~new_sample_q;

  // After a pulse, old_sample takes the 0 from new_sample, so the pulse can
  // never be two cycles wide.
  a_single_cycle_pulse: assert property (
    @(posedge clk) disable iff (!n_rst)
    bus.start_bit_detected |=> !bus.start_bit_detected
  );

endmodule

// File: tb/tb_start_bit_det.sv
// Testbench for start_bit_det: directed scenarios plus randomized line activity,
// each cycle compared against a history-based reference model.
// The model keeps the line value seen at each edge and looks back SYNC_STAGES edges.
module tb_start_bit_det;
  localparam int S = 2;

  logic clk = 1'b0;
  logic n_rst;

  start_bit_det_if bus ();

  start_bit_det #(.SYNC_STAGES(S)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulses       = 0;
  bit prev_out     = 1'b0;
  bit outs[$];

  // Line values captured at each rising edge; reset fills it with idle ones.
  bit hist[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b1);
  endtask

  // A pulse is due after an edge when the value seen S edges ago was 1 and the
  // value seen S-1 edges ago was 0.
  function automatic bit model_pulse();
    return hist[hist.size()-1-S] & ~hist[hist.size()-S];
  endfunction

  // Drive one line value for one clock, then compare on the falling edge.
  task automatic step(input bit v, input string tag);
    bit cur;
    bus.serial_in = v;
    @(posedge clk);
    hist.push_back(v);
    if (hist.size() > 64) void'(hist.pop_front());
    @(negedge clk);
    cur = bus.start_bit_detected;
    check_eq(tag, {31'd0, cur}, {31'd0, model_pulse()});
    check_eq({tag, "_gap"}, {31'd0, prev_out & cur}, 32'd0);
    if (cur) pulses++;
    outs.push_back(cur);
    prev_out = cur;
  endtask

  task automatic do_reset(input bit line);
    @(negedge clk);
    bus.serial_in = line;
    n_rst = 1'b0;
    model_reset();
    prev_out = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_out", {31'd0, bus.start_bit_detected}, 32'd0);
    check_eq("rst_chain", {29'd0, dut.sync_q, dut.new_sample_q, dut.old_sample_q},
             (32'd1 << (S + 1)) - 1);
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    bus.serial_in = 1'b1;
    model_reset();

    // Idle line: no pulse at or after release.
    do_reset(1'b1);
    pulses = 0;
    for (int i = 0; i < 8; i++) step(1'b1, "idle");
    check_eq("idle_pulses", pulses, 0);

    // Falling edge held low: one pulse, after the S-th edge.
    pulses = 0;
    outs.delete();
    for (int i = 0; i < 6; i++) step(1'b0, "fall");
    check_eq("fall_pulses", pulses, 1);
    check_eq("fall_pos", {31'd0, outs[S-1]}, 32'd1);

    // Rising edge after a long low: no pulse.
    pulses = 0;
    for (int i = 0; i < 5; i++) step(1'b1, "rise");
    check_eq("rise_pulses", pulses, 0);

    // Alternating line, 6 periods: one pulse per falling edge.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, "alt");
      step(1'b0, "alt");
    end
    for (int i = 0; i < S + 1; i++) step(1'b1, "alt_tail");
    check_eq("alt_pulses", pulses, 6);

    // Line low through reset and after release: one pulse S edges after release.
    do_reset(1'b0);
    pulses = 0;
    outs.delete();
    for (int i = 0; i < 6; i++) step(1'b0, "rst_low");
    check_eq("rst_low_pulses", pulses, 1);
    check_eq("rst_low_pos", {31'd0, outs[S-1]}, 32'd1);

    // Reset asserted while the pulse is high drops it without a clock edge.
    for (int i = 0; i < 4; i++) step(1'b1, "pre_mid");
    for (int i = 0; i < S; i++) step(1'b0, "mid");
    check_eq("mid_pulse_high", {31'd0, bus.start_bit_detected}, 32'd1);
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_out", {31'd0, bus.start_bit_detected}, 32'd0);
    check_eq("mid_rst_chain", {29'd0, dut.sync_q, dut.new_sample_q, dut.old_sample_q},
             (32'd1 << (S + 1)) - 1);
    model_reset();
    prev_out = 1'b0;
    @(negedge clk);
    bus.serial_in = 1'b1;
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, "post_mid");

    // Random runs of 1..4 cycles, including single-cycle glitches.
    for (int r = 0; r < 150; r++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) step(v, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
